// File: rtl/moving_block_renderer.sv
// Paints one solid rectangle over a background on the VGA pixel stream; the rectangle
// steps once per MOVE_DIV frames, either under button control or bouncing between bounds.
module moving_block_renderer #(
  parameter int          HALF_W    = 150,
  parameter int          HALF_H    = 90,
  parameter logic [11:0] COLOR     = 12'h0F0,
  parameter int          START_X   = 450,
  parameter int          START_Y   = 150,
  parameter int          X_MIN     = 294,
  parameter int          X_MAX     = 633,
  parameter int          Y_MIN     = 125,
  parameter int          Y_MAX     = 425,
  parameter int          STEP      = 2,
  parameter int          MOVE_DIV  = 1,
  parameter int          TICK_LINE = 516
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bright,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic [11:0] background,
  input  logic        mode,
  input  logic        pause,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic        btn_l,
  input  logic        btn_r,
  output logic [11:0] rgb,
  output logic [9:0]  xpos,
  output logic [9:0]  ypos,
  output logic        hit_edge
);

  localparam logic [10:0] STEP_W   = 11'(STEP);
  localparam logic [10:0] HW       = 11'(HALF_W);
  localparam logic [10:0] HH       = 11'(HALF_H);
  localparam logic [10:0] XMIN_W   = 11'(X_MIN);
  localparam logic [10:0] XMAX_W   = 11'(X_MAX);
  localparam logic [10:0] YMIN_W   = 11'(Y_MIN);
  localparam logic [10:0] YMAX_W   = 11'(Y_MAX);
  localparam logic [15:0] DIV_LAST = 16'(MOVE_DIV - 1);

  logic        cond, cond_q, tick, step;
  logic [15:0] fdiv_q, fdiv_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic        hit_q, hit_d;
  logic [11:0] rgb_q, rgb_d;
  logic [12:0] ax_x, ax_y;
  logic        fill;
  logic [10:0] h11, v11, x11, y11;

  // One axis step, all in 11 bits. Result packs {hit, new_dir, new_pos}; dir 1 means +STEP.
  function automatic logic [12:0] axis_step(input logic [9:0] pos, input logic dir,
                                            input logic bounce, input logic inc,
                                            input logic dec, input logic [10:0] lo,
                                            input logic [10:0] hi);
    logic [10:0] p, up, dn, sel, res;
    logic        nd;
    p   = {1'b0, pos};
    up  = p + STEP_W;
    dn  = (p < STEP_W) ? 11'd0 : p - STEP_W;
    nd  = dir;
    sel = p;
    res = p;
    if (bounce) begin
      sel = dir ? up : dn;
      if (sel >= hi) begin
        res = hi;
        nd  = 1'b0;
      end else if (sel <= lo) begin
        res = lo;
        nd  = 1'b1;
      end else begin
        res = sel;
      end
    end else begin
      sel = (inc && !dec) ? up : (dec && !inc) ? dn : p;
      res = (sel < lo) ? lo : (sel > hi) ? hi : sel;
    end
    return {((res == lo) || (res == hi)) && ((res != p) || (nd != dir)), nd, res};
  endfunction

  // Rising-edge detect: hCount dwells on 0 for several clocks, but only the first counts.
  assign cond = (hCount == 10'd0) && (vCount == 10'(TICK_LINE));
  assign tick = cond && !cond_q;
  assign step = tick && !pause && (fdiv_q == DIV_LAST);

  assign ax_x = axis_step(x_q, dir_x_q, mode, btn_r, btn_l, XMIN_W, XMAX_W);
  assign ax_y = axis_step(y_q, dir_y_q, mode, btn_d, btn_u, YMIN_W, YMAX_W);

  assign h11  = {1'b0, hCount};
  assign v11  = {1'b0, vCount};
  assign x11  = {1'b0, x_q};
  assign y11  = {1'b0, y_q};
  assign fill = (h11 + HW >= x11) && (h11 <= x11 + HW) &&
                (v11 + HH >= y11) && (v11 <= y11 + HH);

  always_comb begin
    fdiv_d  = fdiv_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    hit_d   = 1'b0;
    rgb_d   = !bright ? 12'h000 : (fill ? COLOR : background);
    if (tick && !pause) begin
      fdiv_d = (fdiv_q == DIV_LAST) ? 16'd0 : fdiv_q + 16'd1;
    end
    if (step) begin
      x_d     = ax_x[9:0];
      y_d     = ax_y[9:0];
      dir_x_d = ax_x[11];
      dir_y_d = ax_y[11];
      hit_d   = ax_x[12] || ax_y[12];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cond_q  <= 1'b0;
      fdiv_q  <= 16'd0;
      x_q     <= 10'(START_X);
      y_q     <= 10'(START_Y);
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
      hit_q   <= 1'b0;
      rgb_q   <= 12'h000;
    end else begin
      cond_q  <= cond;
      fdiv_q  <= fdiv_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      hit_q   <= hit_d;
      rgb_q   <= rgb_d;
    end
  end

  assign rgb      = rgb_q;
  assign xpos     = x_q;
  assign ypos     = y_q;
  assign hit_edge = hit_q;

endmodule
